// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the slice-sequenced adder: slice width and controller state encoding.
package add_seq_ctrl_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ADD_CLA_8.sv
// 8-bit carry-lookahead adder slice; every carry is formed directly from the generate/propagate terms.
module ADD_CLA_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       ci,
   output logic [7:0] s,
   output logic       co,
   output logic       g,
   output logic       p
);

   logic [7:0] gb;
   logic [7:0] pb;
   logic [8:0] c;

   assign gb = a & b;
   assign pb = a ^ b;

   // c[i] = G[i-1:0] | P[i-1:0]&ci, expanded as a flat sum of products
   always_comb begin
      logic t;
      c    = '0;
      t    = 1'b0;
      c[0] = ci;
      for (int i = 1; i <= 8; i++) begin
         t = ci;
         for (int m = 0; m < i; m++) t = t & pb[m];
         c[i] = t;
         for (int j = 0; j < i; j++) begin
            t = gb[j];
            for (int m = j + 1; m < i; m++) t = t & pb[m];
            c[i] = c[i] | t;
         end
      end
   end

   always_comb begin
      logic t;
      g = 1'b0;
      t = 1'b0;
      for (int j = 0; j < 8; j++) begin
         t = gb[j];
         for (int m = j + 1; m < 8; m++) t = t & pb[m];
         g = g | t;
      end
   end

   assign p  = &pb;
   assign s  = pb ^ c[7:0];
   assign co = c[8];

endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer reusing one 8-bit CLA slice, LSB slice first,
// with the slice carry registered between cycles and valid/ready on both sides.
module add_seq_ctrl
   import add_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             iClk,
   input  logic             iRst_n,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iSub,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oS,
   output logic             oC,
   output logic             oV,
   output logic             oZ
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

   state_t             st;
   state_t             st_nxt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   beff_q;
   logic [WIDTH-1:0]   s_q;
   logic [WIDTH-1:0]   s_upd;
   logic               carry_q;
   logic               c_q;
   logic               v_q;
   logic               z_q;
   logic [IDX_W-1:0]   idx_q;
   logic [SLICE_W-1:0] a_slc;
   logic [SLICE_W-1:0] b_slc;
   logic [SLICE_W-1:0] slc_s;
   logic               slc_co;
   logic               unused_g;
   logic               unused_p;
   logic               last_slc;

   assign a_slc    = a_q[idx_q*SLICE_W +: SLICE_W];
   assign b_slc    = beff_q[idx_q*SLICE_W +: SLICE_W];
   assign last_slc = (idx_q == IDX_LAST);

   ADD_CLA_8 u_slice (
      .a  (a_slc),
      .b  (b_slc),
      .ci (carry_q),
      .s  (slc_s),
      .co (slc_co),
      .g  (unused_g),
      .p  (unused_p)
   );

   // Result with the current slice merged in; flags on the last slice are taken from this
   always_comb begin
      s_upd = s_q;
      s_upd[idx_q*SLICE_W +: SLICE_W] = slc_s;
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) st <= IDLE;
      else         st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (iValid)   st_nxt = RUN;
         RUN:     if (last_slc) st_nxt = DONE;
         DONE:    if (iReady)   st_nxt = IDLE;
         default:               st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         a_q     <= '0;
         beff_q  <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         case (st)
            IDLE: begin
               if (iValid) begin
                  a_q     <= iA;
                  beff_q  <= iSub ? ~iB : iB;
                  carry_q <= iSub;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               s_q     <= s_upd;
               carry_q <= slc_co;
               idx_q   <= idx_q + IDX_W'(1);
               if (last_slc) begin
                  c_q <= slc_co;
                  v_q <= (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (s_upd[WIDTH-1] != a_q[WIDTH-1]);
                  z_q <= (s_upd == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign oReady = (st == IDLE);
   assign oValid = (st == DONE);
   assign oS     = s_q;
   assign oC     = c_q;
   assign oV     = v_q;
   assign oZ     = z_q;

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add/subtract by time-multiplexing one 8-bit carry-lookahead adder slice.
- Processes one 8-bit slice per cycle, LSB first, with the slice carry-out registered into the next slice's carry-in.
- Sits in front of the floating-point mantissa/exponent datapath where area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8 and at least 8.
- NSLICE, WIDTH/8, derived slice count; not overridable.

Ports:
- iClk  in  1  clock, rising edge.
- iRst_n  in  1  synchronous active-low reset.
- iValid  in  1  operand request.
- oReady  out  1  controller can accept operands.
- iA  in  WIDTH  operand A.
- iB  in  WIDTH  operand B.
- iSub  in  1  1 = A−B, 0 = A+B.
- oValid  out  1  result valid.
- iReady  in  1  consumer accepts result.
- oS  out  WIDTH  sum/difference.
- oC  out  1  carry-out of MSB slice; for subtract, 1 = no borrow.
- oV  out  1  signed two's-complement overflow.
- oZ  out  1  result equals zero.

Behaviour:
- Reset: when iRst_n=0 at a rising edge, state ← IDLE and all registers ← 0. After reset: oReady=1, oValid=0, oS=0, oC=0, oV=0, oZ=0.
- Reset mid-operation aborts the operation; the in-flight result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - oReady=1.
  - On iValid&oReady: latch A←iA, Beff←iSub ? ~iB : iB, carry←iSub, idx←0; go to RUN.
- RUN:
  - oReady=0.
  - Each cycle, the slice adder computes A[8·idx+7:8·idx] + Beff[same] + carry.
  - The result is written into oS[same]; carry ← slice carry-out; idx ← idx+1.
  - When idx==NSLICE−1, go to DONE.
- DONE:
  - oValid=1; oS, oC, oV, oZ are held stable.
  - On iReady, go to IDLE; oValid drops on the next cycle.
  - No back-to-back accept from DONE: a new accept needs at least one IDLE cycle.
- Latency: with the accept edge as edge 0, oValid is first high after edge NSLICE (4 cycles for WIDTH=32).
- Throughput: one operation per NSLICE+2 cycles at most.
- Operand isolation: iA, iB, iSub and iValid are ignored in RUN and DONE. Operands are latched only in IDLE.
- Flags:
  - oC = final carry register.
  - oV = (A[MSB]==Beff[MSB]) && (oS[MSB]!=A[MSB]).
  - oZ = (oS==0).
  - All flags are registered and valid exactly when oValid=1.
- oS holds its previous value outside DONE, except that slices are overwritten progressively during RUN. Consumers may sample it only when oValid=1.
- idx width is clog2(NSLICE), minimum 1 bit.
- When NSLICE=1, RUN lasts exactly one cycle.
- Slice adder carry semantics: carry-in of slice k equals carry-out of slice k−1, registered. Slice G/P outputs are unused.

Decomposition:
- Shared package:
  - SLICE_W=8.
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is unreachable and recovers to IDLE.
- One sub-module: an instance of the existing 8-bit CLA slice ADD_CLA_8.
- All sequencing, muxing of the operand slice and the carry register live in add_seq_ctrl.

Test Plan:
- Carry ripple across slices: A=0x0000FFFF, B=0x00000001, add → oS=0x00010000, oC=0, oV=0, oZ=0; oValid high exactly 4 cycles after the accept edge.
- Full wrap: A=0xFFFFFFFF, B=0x00000001, add → oS=0x00000000, oC=1, oZ=1, oV=0. Subtract with borrow: A=5, B=7, sub → oS=0xFFFFFFFE, oC=0, oV=0.
- Signed overflow: A=0x7FFFFFFF, B=1, add → oV=1, oS=0x80000000. Then A=0x80000000, B=1, sub → oV=1, oS=0x7FFFFFFF.
- Backpressure and isolation: hold iReady=0 for 5 cycles in DONE → oValid and oS stay constant; toggle iA/iB/iValid during RUN → result unaffected and no second accept; oReady returns to 1 one cycle after the iReady handshake.
- Reset mid-operation: assert iRst_n=0 for one cycle at idx=2 → next cycle oValid=0, oReady=1, oS=0. A fresh request A=3, B=4 then yields oS=7.
- Parameter sweep: WIDTH=8 and WIDTH=64 with random operands vs a reference model → latency equals NSLICE cycles; oS, oC, oV, oZ all match.
